// File: rtl/fetch_queue.sv
// Decoupling instruction queue between fetch stage 1 and decode.
// Bundles are truncated after the first predicted-taken slot; up to 4 oldest entries are presented per cycle.
module fetch_queue #(
    parameter int DEPTH  = 16,
    parameter int INST_W = 64,
    parameter int PC_W   = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_i,
    input  logic                          enqValid_i,
    input  logic [4*INST_W-1:0]           bundle_i,
    input  logic [PC_W-1:0]               pc_i,
    input  logic [3:0]                    btbHit_i,
    input  logic [7:0]                    ctrlType_i,
    input  logic [3:0]                    prediction_i,
    input  logic [4*PC_W-1:0]             targetAddr_i,
    output logic                          stall_o,
    input  logic                          deqReady_i,
    output logic [3:0]                    deqValid_o,
    output logic [4*INST_W-1:0]           deqInst_o,
    output logic [4*PC_W-1:0]             deqPC_o,
    output logic [3:0]                    deqTaken_o,
    output logic [4*PC_W-1:0]             deqTarget_o,
    output logic [$clog2(DEPTH):0]        count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [INST_W-1:0] instMem   [DEPTH];
    logic [PC_W-1:0]   pcMem     [DEPTH];
    logic [PC_W-1:0]   targetMem [DEPTH];
    logic              takenMem  [DEPTH];

    logic [PTR_W-1:0] headReg, headNext;
    logic [PTR_W-1:0] tailReg, tailNext;
    logic [CW-1:0]    countReg, countNext;
    logic [CW-1:0]    freeSlots;

    logic [3:0] taken;
    logic [2:0] enqCount;
    logic [2:0] deqNum;
    logic       doEnq;

    // Non-conditional BTB hits are always taken; conditionals follow the predictor.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gTaken
            assign taken[gi] = btbHit_i[gi] &
                               (prediction_i[gi] | (ctrlType_i[2*gi +: 2] != 2'b11));
        end
    endgenerate

    always_comb begin
        enqCount = 3'd4;
        for (int k = 3; k >= 0; k--) begin
            if (taken[k]) begin
                enqCount = 3'(k + 1);
            end
        end
    end

    // Space is judged on the registered count only so stall never depends on deqReady_i.
    assign freeSlots = CW'(DEPTH) - countReg;
    assign stall_o   = freeSlots < CW'(4);
    assign doEnq     = enqValid_i & ~stall_o;
    assign count_o   = countReg;

    always_comb begin
        deqNum = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (deqValid_o[k]) begin
                deqNum = deqNum + 3'd1;
            end
        end
    end

    always_comb begin
        countNext = countReg;
        headNext  = headReg;
        tailNext  = tailReg;
        if (doEnq) begin
            countNext = countNext + CW'(enqCount);
            tailNext  = tailReg + PTR_W'(enqCount);
        end
        if (deqReady_i) begin
            countNext = countNext - CW'(deqNum);
            headNext  = headReg + PTR_W'(deqNum);
        end
        if (flush_i) begin
            countNext = '0;
            headNext  = '0;
            tailNext  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            countReg <= '0;
            headReg  <= '0;
            tailReg  <= '0;
        end else begin
            countReg <= countNext;
            headReg  <= headNext;
            tailReg  <= tailNext;
        end
    end

    // Storage is not reset; pointer wrap splits a bundle across the end and start of the arrays.
    always_ff @(posedge clk) begin
        if (doEnq && !reset && !flush_i) begin
            for (int k = 0; k < 4; k++) begin
                if (enqCount > 3'(k)) begin
                    instMem[tailReg + PTR_W'(k)]   <= bundle_i[k*INST_W +: INST_W];
                    pcMem[tailReg + PTR_W'(k)]     <= pc_i + PC_W'(8 * k);
                    takenMem[tailReg + PTR_W'(k)]  <= taken[k];
                    targetMem[tailReg + PTR_W'(k)] <= targetAddr_i[k*PC_W +: PC_W];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gRead
            logic [PTR_W-1:0] rdIdx;
            assign rdIdx                          = headReg + PTR_W'(gi);
            assign deqValid_o[gi]                 = countReg > CW'(gi);
            assign deqInst_o[gi*INST_W +: INST_W] = instMem[rdIdx];
            assign deqPC_o[gi*PC_W +: PC_W]       = pcMem[rdIdx];
            assign deqTaken_o[gi]                 = takenMem[rdIdx];
            assign deqTarget_o[gi*PC_W +: PC_W]   = targetMem[rdIdx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (countReg <= CW'(DEPTH));
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: truncation, backpressure, wrap-around and flush.
module tb_fetch_queue;
    logic         clk = 1'b0;
    logic         reset;
    logic         flush_i;
    logic         enqValid_i;
    logic [255:0] bundle_i;
    logic [31:0]  pc_i;
    logic [3:0]   btbHit_i;
    logic [7:0]   ctrlType_i;
    logic [3:0]   prediction_i;
    logic [127:0] targetAddr_i;
    logic         stall_o;
    logic         deqReady_i;
    logic [3:0]   deqValid_o;
    logic [255:0] deqInst_o;
    logic [127:0] deqPC_o;
    logic [3:0]   deqTaken_o;
    logic [127:0] deqTarget_o;
    logic [4:0]   count_o;

    int checks = 0;
    int failures = 0;

    fetch_queue #(.DEPTH(16), .INST_W(64), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .enqValid_i(enqValid_i),
        .bundle_i(bundle_i), .pc_i(pc_i), .btbHit_i(btbHit_i), .ctrlType_i(ctrlType_i),
        .prediction_i(prediction_i), .targetAddr_i(targetAddr_i), .stall_o(stall_o),
        .deqReady_i(deqReady_i), .deqValid_o(deqValid_o), .deqInst_o(deqInst_o),
        .deqPC_o(deqPC_o), .deqTaken_o(deqTaken_o), .deqTarget_o(deqTarget_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slot k instruction encodes its own PC in the low word.
    task automatic setBundle(input logic [31:0] pc, input logic [3:0] hit, input logic [7:0] ctype,
                             input logic [3:0] pred, input logic [127:0] tgt);
        pc_i         = pc;
        btbHit_i     = hit;
        ctrlType_i   = ctype;
        prediction_i = pred;
        targetAddr_i = tgt;
        for (int k = 0; k < 4; k++) begin
            bundle_i[k*64 +: 64] = {32'hC0DE_0000, pc + 32'(8 * k)};
        end
    endtask

    task automatic enqOnce(input logic [31:0] pc, input logic [3:0] hit, input logic [7:0] ctype,
                           input logic [3:0] pred, input logic [127:0] tgt);
        setBundle(pc, hit, ctype, pred, tgt);
        enqValid_i = 1'b1;
        tick();
        enqValid_i = 1'b0;
    endtask

    task automatic drain();
        deqReady_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        deqReady_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush_i = 1'b0; enqValid_i = 1'b0; deqReady_i = 1'b0;
        setBundle(32'h0, 4'b0, 8'b0, 4'b0, 128'b0);
        tick(); tick();
        reset = 1'b0;
        checkVal("reset_count", 256'(count_o), 256'd0);
        checkVal("reset_valid", 256'(deqValid_o), 256'h0);
        checkVal("reset_stall", 256'(stall_o), 256'd0);

        // Plain 4-instruction bundle
        enqOnce(32'h100, 4'b0000, 8'h00, 4'b0000, 128'b0);
        checkVal("plain_count", 256'(count_o), 256'd4);
        checkVal("plain_valid", 256'(deqValid_o), 256'hF);
        checkVal("plain_pcs", 256'(deqPC_o), 256'h0000_0118_0000_0110_0000_0108_0000_0100);
        checkVal("plain_inst0", 256'(deqInst_o[63:0]), 256'hC0DE_0000_0000_0100);
        drain();
        checkVal("drain_count", 256'(count_o), 256'd0);
        checkVal("drain_valid", 256'(deqValid_o), 256'h0);

        // Conditional taken in slot 1 truncates to 2
        enqOnce(32'h200, 4'b0010, 8'b0000_1100, 4'b0010, {32'h0, 32'h0, 32'h400, 32'h0});
        checkVal("cond_t_count", 256'(count_o), 256'd2);
        checkVal("cond_t_valid", 256'(deqValid_o), 256'h3);
        checkVal("cond_t_taken", 256'(deqTaken_o[1:0]), 256'h2);
        checkVal("cond_t_target1", 256'(deqTarget_o[63:32]), 256'h400);
        checkVal("cond_t_pc1", 256'(deqPC_o[63:32]), 256'h208);
        drain();

        // Same hit but predicted not-taken keeps the full bundle
        enqOnce(32'h300, 4'b0010, 8'b0000_1100, 4'b0000, {32'h0, 32'h0, 32'h400, 32'h0});
        checkVal("cond_nt_count", 256'(count_o), 256'd4);
        checkVal("cond_nt_taken", 256'(deqTaken_o), 256'h0);
        drain();

        // Unconditional jump in slot 2 is taken regardless of prediction
        enqOnce(32'h500, 4'b0100, 8'b0010_0000, 4'b0000, {32'h0, 32'h640, 32'h0, 32'h0});
        checkVal("jump_count", 256'(count_o), 256'd3);
        checkVal("jump_valid", 256'(deqValid_o), 256'h7);
        checkVal("jump_taken", 256'(deqTaken_o[2:0]), 256'h4);
        checkVal("jump_pc2", 256'(deqPC_o[95:64]), 256'h510);
        drain();

        // Fill to 13 with no dequeue
        enqOnce(32'h1000, 4'b0, 8'h00, 4'b0, 128'b0);
        enqOnce(32'h1020, 4'b0, 8'h00, 4'b0, 128'b0);
        enqOnce(32'h1040, 4'b0, 8'h00, 4'b0, 128'b0);
        checkVal("fill12_count", 256'(count_o), 256'd12);
        checkVal("fill12_stall", 256'(stall_o), 256'd0);
        enqOnce(32'h1060, 4'b0001, 8'b0000_0010, 4'b0, 128'b0);
        checkVal("fill13_count", 256'(count_o), 256'd13);
        checkVal("fill13_stall", 256'(stall_o), 256'd1);
        enqOnce(32'h1080, 4'b0, 8'h00, 4'b0, 128'b0);
        checkVal("stalled_count", 256'(count_o), 256'd13);
        checkVal("full_head_pc", 256'(deqPC_o[31:0]), 256'h1000);
        deqReady_i = 1'b1;
        tick();
        deqReady_i = 1'b0;
        checkVal("unstall_count", 256'(count_o), 256'd9);
        checkVal("unstall_stall", 256'(stall_o), 256'd0);
        checkVal("unstall_head_pc", 256'(deqPC_o[31:0]), 256'h1020);
        drain();
        checkVal("empty_count", 256'(count_o), 256'd0);

        // Sustained 4-in/4-out; pointers wrap several times
        enqOnce(32'h3000, 4'b0, 8'h00, 4'b0, 128'b0);
        enqValid_i = 1'b1;
        deqReady_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            setBundle(32'h3000 + 32'(i * 32), 4'b0, 8'h00, 4'b0, 128'b0);
            tick();
            checkVal($sformatf("stream%0d_count", i), 256'(count_o), 256'd4);
            checkVal($sformatf("stream%0d_pc0", i), 256'(deqPC_o[31:0]), 256'(32'h3000 + 32'(i * 32)));
            checkVal($sformatf("stream%0d_pc3", i), 256'(deqPC_o[127:96]), 256'(32'h3018 + 32'(i * 32)));
        end
        enqValid_i = 1'b0;
        drain();

        // Flush beats a same-cycle enqueue and dequeue
        enqOnce(32'h4000, 4'b0, 8'h00, 4'b0, 128'b0);
        enqOnce(32'h4020, 4'b0, 8'h00, 4'b0, 128'b0);
        checkVal("preflush_count", 256'(count_o), 256'd8);
        setBundle(32'h4040, 4'b0, 8'h00, 4'b0, 128'b0);
        flush_i = 1'b1; enqValid_i = 1'b1; deqReady_i = 1'b1;
        tick();
        flush_i = 1'b0; enqValid_i = 1'b0; deqReady_i = 1'b0;
        checkVal("flush_count", 256'(count_o), 256'd0);
        checkVal("flush_valid", 256'(deqValid_o), 256'h0);
        enqOnce(32'h200, 4'b0, 8'h00, 4'b0, 128'b0);
        checkVal("postflush_count", 256'(count_o), 256'd4);
        checkVal("postflush_pc0", 256'(deqPC_o[31:0]), 256'h200);
        checkVal("postflush_inst3", 256'(deqInst_o[255:192]), 256'hC0DE_0000_0000_0218);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling instruction queue between fetch stage 1 and decode.
- Accepts one 4-instruction bundle per cycle from fetch stage 1, together with its PC and per-slot BTB/prediction info.
- Truncates the bundle after the first predicted-taken slot, stores the surviving instructions in a circular buffer, and presents up to 4 oldest entries to decode per cycle.
- Drives backpressure (stall) to fetch stage 1 when it cannot guarantee space for a full bundle.

Parameters:
- DEPTH, 16, number of instruction entries; power of two, at least 8.
- INST_W, 64, width of one instruction.
- PC_W, 32, PC width (`SIZE_PC).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all entries (mispredict/exception recovery).
- enqValid_i  in  1  bundle present; fetch stage 1 is ready and not stalled.
- bundle_i  in  4*INST_W  slot k at bits [k*INST_W +: INST_W].
- pc_i  in  PC_W  PC of slot 0; slot k PC = pc_i + 8*k.
- btbHit_i  in  4  per-slot BTB hit.
- ctrlType_i  in  8  per-slot 2-bit type: 00 return, 01 call, 10 jump, 11 conditional.
- prediction_i  in  4  per-slot direction prediction.
- targetAddr_i  in  4*PC_W  per-slot predicted target.
- stall_o  out  1  fetch stage 1 must hold.
- deqReady_i  in  1  decode accepts the presented entries this cycle.
- deqValid_o  out  4  valid mask of the presented slots; always contiguous from bit 0.
- deqInst_o  out  4*INST_W  head entries, oldest in slot 0.
- deqPC_o  out  4*PC_W  PC of each presented entry.
- deqTaken_o  out  4  entry was predicted taken.
- deqTarget_o  out  4*PC_W  predicted target of each presented entry.
- count_o  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Per-slot taken predicate: taken[k] = btbHit_i[k] & (prediction_i[k] | ctrlType_i[k] != 2'b11).
- Enqueue count n = 1 + index of the lowest set taken bit; n = 4 if no bit is set.
- Only slots 0..n-1 are written, in order. Each entry stores inst, pc_i+8k, taken[k], and targetAddr[k].
- stall_o = (DEPTH - count) < 4. This is combinational on the current registered count only; same-cycle dequeue is not credited.
- An enqueue occurs at posedge when enqValid_i & ~stall_o. If enqValid_i is asserted while stall_o = 1, the bundle is ignored; upstream holds it.
- Outputs are read combinationally from the head pointer. deqValid_o[k] = (count > k).
- Latency: an entry enqueued at edge N is visible on deq outputs in the cycle after edge N. There is no bypass.
- Dequeue at posedge when deqReady_i: removes popcount(deqValid_o) entries.
- Simultaneous enqueue and dequeue: count_next = count + n - d. Head and tail pointers both advance modulo DEPTH.
- Pointers are log2(DEPTH)-bit and wrap naturally. A bundle straddling the wrap boundary is written split across the end and the start of storage.
- Flush: count, head, and tail go to 0 at posedge. Flush overrides any same-cycle enqueue and dequeue.
- Reset:
  - Same effect as flush; reset has priority over flush.
  - After reset: count_o = 0, deqValid_o = 4'b0000, stall_o = 0.
  - Data outputs are don't-care while their valid bit is 0.
  - Storage arrays are not reset.
- Empty: deqValid_o = 0, and deqReady_i has no effect.
- Full: count never exceeds DEPTH. Overflow and underflow are impossible by construction; an assertion flags any violation.
- Reset or flush mid-stream: no partial bundle survives, and the first enqueue afterwards lands at entry 0.

Test Plan:
- Reset, then enqueue a bundle at pc=0x100 with no BTB hits → next cycle count_o=4, deqValid_o=4'b1111, deqPC_o = 0x100/0x108/0x110/0x118.
- Slot 1 btbHit=1, type=11, pred=1, target=0x400 → only 2 entries written; entry 1 has deqTaken=1, deqTarget=0x400. Repeat with pred=0 → 4 entries.
- Slot 2 hit with type=10 and pred=0 → 3 entries written (non-conditional hits are always taken).
- Enqueue every cycle with deqReady_i=0 until count=13 → stall_o=1, and a further enqValid_i leaves count at 13. Raise deqReady_i → count drops to 9, stall_o falls.
- Sustained 4-in/4-out for 10 cycles from count=4 → count stays 4; wrap-around occurs and PCs stay in order with no gaps.
- flush_i asserted together with enqValid_i and deqReady_i at count=8 → count_o=0 and deqValid_o=0 next cycle. The following bundle at pc=0x200 appears in slot 0.
